// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM states and helpers shared by the ALU arbiter slice
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_NOT = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_NOR = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8;
  localparam logic [3:0] OP_ASR = 4'h9;
  localparam logic [3:0] OP_ROL = 4'hA;
  localparam logic [3:0] OP_ROR = 4'hB;
  localparam logic [3:0] OP_EQ  = 4'hC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - shared 8-bit combinational ALU
module alu
  import alu_pkg::*;
(
  input  logic [3:0] ctrl,
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] out,
  output logic       carry
);

  logic [8:0] sum;
  logic [8:0] diff;

  // Sign-extended so bit 8 reflects the signed result's sign
  assign sum  = {x[7], x} + {y[7], y};
  assign diff = {x[7], x} - {y[7], y};

  always_comb begin
    out   = '0;
    carry = 1'b0;
    case (ctrl)
      OP_ADD: {carry, out} = sum;
      OP_SUB: {carry, out} = diff;
      OP_AND: out = x & y;
      OP_OR:  out = x | y;
      OP_NOT: out = ~x;
      OP_XOR: out = x ^ y;
      OP_NOR: out = ~(x | y);
      OP_SHL: {carry, out} = {1'b0, y} << x[2:0];
      OP_SHR: out = y >> x[2:0];
      OP_ASR: {out, carry} = {x[7], x};
      OP_ROL: out = {x[6:0], x[7]};
      OP_ROR: out = {x[0], x[7:1]};
      OP_EQ:  out = {7'd0, x == y};
      default: ;
    endcase
  end

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin picker: first valid at or after ptr, with wrap
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] grant,
  output logic             any
);

  logic [PTR_W:0] idx;

  // Scan from the farthest slot down so the closest valid to ptr wins
  always_comb begin
    grant = '0;
    any   = |valid;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (idx >= (PTR_W + 1)'(NREQ)) idx = idx - (PTR_W + 1)'(NREQ);
      if (valid[idx[PTR_W-1:0]]) grant = idx[PTR_W-1:0];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between NREQ requesters
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_ctrl,
  input  logic [8*NREQ-1:0] req_x,
  input  logic [8*NREQ-1:0] req_y,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [7:0]        rsp_out,
  output logic              rsp_carry,
  output logic              busy
);

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] gnt_q;
  logic [PTR_W-1:0] pick;
  logic             any;
  logic [3:0]       ctrl_q;
  logic [7:0]       x_q;
  logic [7:0]       y_q;
  logic [3:0]       sel_ctrl;
  logic [7:0]       sel_x;
  logic [7:0]       sel_y;
  logic [7:0]       alu_out;
  logic             alu_carry;

  rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (pick),
    .any   (any)
  );

  alu u_alu (
    .ctrl  (ctrl_q),
    .x     (x_q),
    .y     (y_q),
    .out   (alu_out),
    .carry (alu_carry)
  );

  always_comb begin
    sel_ctrl = '0;
    sel_x    = '0;
    sel_y    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == PTR_W'(i)) begin
        sel_ctrl = req_ctrl[4*i +: 4];
        sel_x    = req_x[8*i +: 8];
        sel_y    = req_y[8*i +: 8];
      end
    end
  end

  // Gated by rst_n so no accept is offered while reset is held
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && any) req_ready[pick] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_q     <= '0;
      ctrl_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      rsp_valid <= '0;
      rsp_out   <= '0;
      rsp_carry <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            ctrl_q <= sel_ctrl;
            x_q    <= sel_x;
            y_q    <= sel_y;
            gnt_q  <= pick;
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_out   <= alu_out;
          rsp_carry <= alu_carry & is_arith(ctrl_q);
          rsp_valid <= NREQ'(1) << gnt_q;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready[gnt_q]) begin
            rsp_valid <= '0;
            rr_ptr    <= (gnt_q == PTR_W'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with two requesters
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_ctrl;
  logic [15:0] req_x;
  logic [15:0] req_y;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [7:0]  rsp_out;
  logic        rsp_carry;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int ptr   = 0;

  logic [3:0] r_ctrl [2];
  logic [7:0] r_x    [2];
  logic [7:0] r_y    [2];

  alu_arbiter #(.NREQ(2), .PTR_W(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ctrl  (req_ctrl),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_carry (rsp_carry),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Opcode semantics from plain integer arithmetic; returns {carry, out}
  function automatic logic [8:0] alu_ref(input int op, input int x, input int y);
    int sx, sy, r;
    bit c;
    sx = (x > 127) ? x - 256 : x;
    sy = (y > 127) ? y - 256 : y;
    r  = 0;
    c  = 1'b0;
    case (op)
      0:  begin r = sx + sy; c = r[8]; end
      1:  begin r = sx - sy; c = r[8]; end
      2:  r = x & y;
      3:  r = x | y;
      4:  r = ~x;
      5:  r = x ^ y;
      6:  r = ~(x | y);
      7:  r = y << (x % 8);
      8:  r = y >> (x % 8);
      9:  r = sx >>> 1;
      10: r = (x << 1) | (x >> 7);
      11: r = (x >> 1) | ((x & 1) << 7);
      12: r = (x == y) ? 1 : 0;
      default: r = 0;
    endcase
    return {c, 8'(r & 255)};
  endfunction

  function automatic int rr_expect(input logic [1:0] mask);
    for (int k = 0; k < 2; k++) begin
      if (mask[(ptr + k) % 2]) return (ptr + k) % 2;
    end
    return -1;
  endfunction

  task automatic drive_ops();
    req_ctrl = {r_ctrl[1], r_ctrl[0]};
    req_x    = {r_x[1], r_x[0]};
    req_y    = {r_y[1], r_y[0]};
  endtask

  task automatic run_op(input logic [1:0] mask, input int stall, input bit hold, output int g);
    logic [8:0] e;
    logic [1:0] oh;
    @(negedge clk);
    req_valid = mask;
    drive_ops();
    rsp_ready = (stall == 0) ? 2'b11 : 2'b00;
    #1;
    g  = rr_expect(mask);
    oh = 2'b01 << g;
    check("grant", req_ready, oh);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 2'b00;
    @(negedge clk);
    check("exec_valid", rsp_valid, 2'b00);
    check("exec_busy", busy, 1'b1);
    check("exec_ready", req_ready, 2'b00);
    @(negedge clk);
    e = alu_ref(r_ctrl[g], r_x[g], r_y[g]);
    check("rsp_valid", rsp_valid, oh);
    check("rsp_out", rsp_out, e[7:0]);
    check("rsp_carry", rsp_carry, e[8]);
    for (int s = 0; s < stall; s++) begin
      rsp_ready = ~oh;
      @(negedge clk);
      check("stall_valid", rsp_valid, oh);
      check("stall_out", rsp_out, e[7:0]);
      check("stall_busy", busy, 1'b1);
      check("stall_ready", req_ready, 2'b00);
    end
    rsp_ready = oh;
    @(posedge clk);
    #1;
    check("done_valid", rsp_valid, 2'b00);
    check("done_busy", busy, 1'b0);
    rsp_ready = 2'b00;
    ptr = (g + 1) % 2;
  endtask

  initial begin
    int g, prev;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      r_ctrl[i] = '0;
      r_x[i]    = '0;
      r_y[i]    = '0;
    end
    drive_ops();
    #1;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_out", rsp_out, 8'h00);
    check("rst_carry", rsp_carry, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    r_ctrl[0] = 4'h0; r_x[0] = 8'h7F; r_y[0] = 8'h01;
    run_op(2'b01, 0, 1'b0, g);
    check("single_gnt", g, 0);
    check("add_out_const", rsp_out, 8'h80);

    r_ctrl[1] = 4'h1; r_x[1] = 8'h00; r_y[1] = 8'h01;
    run_op(2'b10, 1, 1'b0, g);
    check("sub_carry_const", rsp_carry, 1'b1);
    r_ctrl[1] = 4'h2; r_x[1] = 8'hFF; r_y[1] = 8'h0F;
    run_op(2'b10, 0, 1'b0, g);
    check("and_carry_const", rsp_carry, 1'b0);

    r_ctrl[0] = 4'h5; r_x[0] = 8'hA5; r_y[0] = 8'h3C;
    r_ctrl[1] = 4'h6; r_x[1] = 8'h12; r_y[1] = 8'h40;
    prev = -1;
    for (int n = 0; n < 4; n++) begin
      run_op(2'b11, 0, 1'b1, g);
      check("rr_order", g, n % 2);
      if (prev >= 0) check("rr_alternate", (g != prev), 1);
      prev = g;
    end

    r_ctrl[0] = 4'h3; r_x[0] = 8'h0F; r_y[0] = 8'hF0;
    r_ctrl[1] = 4'h4; r_x[1] = 8'h55; r_y[1] = 8'h00;
    run_op(2'b11, 5, 1'b1, g);
    check("bp_gnt", g, 0);
    check("bp_next", req_ready, 2'b01 << rr_expect(2'b11));
    run_op(2'b10, 0, 1'b0, g);

    r_ctrl[1] = 4'h7; r_x[1] = 8'h03; r_y[1] = 8'h11;
    run_op(2'b10, 0, 1'b0, g);
    check("shl_const", rsp_out, 8'h88);
    r_ctrl[0] = 4'hC; r_x[0] = 8'h5A; r_y[0] = 8'h5A;
    run_op(2'b01, 0, 1'b0, g);
    check("eq_const", rsp_out, 8'h01);

    // Reset while the grant sits in EXEC
    @(negedge clk);
    r_ctrl[0] = 4'h0; r_x[0] = 8'h10; r_y[0] = 8'h20;
    drive_ops();
    req_valid = 2'b01;
    #1;
    check("pre_rst_grant", req_ready, 2'b01 << rr_expect(2'b01));
    @(posedge clk);
    #1;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", req_ready, 2'b00);
    check("mid_rst_valid", rsp_valid, 2'b00);
    check("mid_rst_out", rsp_out, 8'h00);
    check("mid_rst_carry", rsp_carry, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    rst_n = 1'b1;
    ptr = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("post_rst_valid", rsp_valid, 2'b00);
      check("post_rst_busy", busy, 1'b0);
    end
    run_op(2'b11, 0, 1'b0, g);
    check("post_rst_first", g, 0);

    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 2; i++) begin
        r_ctrl[i] = 4'($urandom_range(0, 15));
        r_x[i]    = 8'($urandom);
        r_y[i]    = 8'($urandom);
      end
      run_op(2'($urandom_range(1, 3)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), g);
    end
    req_valid = 2'b00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
